// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned MASK_W = WORD_W / 8;

    // Which requester owns the RAM read that is currently in flight
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_D  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_streak_guard.sv
// Counts consecutive data grants taken while a fetch waits and forces the
// fetch through once the streak limit is reached.
module arb_streak_guard #(
    parameter int unsigned MAX_D_STREAK = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_grant,
    input  logic if_grant,
    output logic force_if
);

    localparam int unsigned CW = $clog2(MAX_D_STREAK + 2);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_D_STREAK);

    logic [CW-1:0] streak;

    // Saturates at the limit; the forced fetch grant then clears it
    always_ff @(posedge clk) begin
        if (rst || !if_req || if_grant) begin
            streak <= '0;
        end else if (d_grant && (streak != LIMIT)) begin
            streak <= streak + 1'b1;
        end
    end

    assign force_if = if_req && (streak >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between an instruction fetch port and a data
// load/store port; grants are combinational, read data returns one cycle later.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int unsigned WORD_AW      = 8,
    parameter int unsigned MAX_D_STREAK = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [WORD_W-1:0]  if_addr,
    output logic [WORD_W-1:0]  if_rdata,
    output logic               if_valid,
    output logic               if_stall,
    input  logic               d_read,
    input  logic               d_write,
    input  logic [WORD_W-1:0]  d_addr,
    input  logic [WORD_W-1:0]  d_wdata,
    input  logic [MASK_W-1:0]  d_mask,
    output logic [WORD_W-1:0]  d_rdata,
    output logic               d_valid,
    output logic               d_stall,
    output logic               ram_en,
    output logic [MASK_W-1:0]  ram_we,
    output logic [WORD_AW-1:0] ram_addr,
    output logic [WORD_W-1:0]  ram_wdata,
    input  logic [WORD_W-1:0]  ram_rdata,
    output logic               err
);

    arb_state_t state, state_nxt;
    logic       d_req;
    logic       grant_d;
    logic       grant_if;
    logic       force_if;
    logic       err_cond;
    logic       err_q;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[WORD_W-1:WORD_AW+2], d_addr[WORD_W-1:WORD_AW+2],
                                d_addr[1:0]};

    arb_streak_guard #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_streak_guard (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .d_grant (grant_d),
        .if_grant(grant_if),
        .force_if(force_if)
    );

    // Data wins unless the fetch has waited out the streak limit
    always_comb begin
        d_req    = d_read | d_write;
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (!rst) begin
            grant_d  = d_req && !force_if;
            grant_if = if_req && !grant_d;
        end
    end

    // A simultaneous read+write is handled as a store
    always_comb begin
        ram_en    = grant_d | grant_if;
        ram_we    = '0;
        ram_wdata = '0;
        ram_addr  = '0;
        if (grant_d) begin
            ram_addr = d_addr[WORD_AW+1:2];
            if (d_write) begin
                ram_we    = d_mask;
                ram_wdata = d_wdata;
            end
        end else if (grant_if) begin
            ram_addr = if_addr[WORD_AW+1:2];
        end
        if_stall = !rst && if_req && !grant_if;
        d_stall  = !rst && d_req && !grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Return path is gated by rst so a read caught by reset never surfaces
    always_comb begin
        state_nxt = IDLE;
        if_valid  = 1'b0;
        d_valid   = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        if (grant_if) begin
            state_nxt = RD_IF;
        end else if (grant_d && !d_write) begin
            state_nxt = RD_D;
        end
        if (!rst) begin
            case (state)
                RD_IF: begin
                    if_valid = 1'b1;
                    if_rdata = ram_rdata;
                end
                RD_D: begin
                    d_valid = 1'b1;
                    d_rdata = ram_rdata;
                end
                default: ;
            endcase
        end
    end

    assign err_cond = (d_read && d_write) || (if_req && (if_addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_cond) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q && !rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a reference model predicts grants and
// read data, a monitor matches returned data against the expectation queues.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 8;
    localparam int unsigned MAXS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic [31:0]   if_rdata;
    logic          if_valid, if_stall;
    logic          d_read = 1'b0, d_write = 1'b0;
    logic [31:0]   d_addr = '0, d_wdata = '0;
    logic [3:0]    d_mask = '0;
    logic [31:0]   d_rdata;
    logic          d_valid, d_stall;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = '0;
    logic          err;

    mem_port_arbiter #(
        .WORD_AW(AW),
        .MAX_D_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_mask(d_mask), .d_rdata(d_rdata),
        .d_valid(d_valid), .d_stall(d_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment RAM driven by the DUT command
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
            else for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t        if_q[$];
    exp_t        d_q[$];
    logic [31:0] ref_mem [256];
    int          streak = 0;
    bit          err_exp = 0;
    bit          ip = 0, dr = 0, dw = 0;
    logic [31:0] ia = '0, da = '0, dwd = '0;
    logic [3:0]  dm = '0;
    string       dut_log = "";

    function automatic logic [AW-1:0] word_of(input logic [31:0] a);
        return AW'((a >> 2) % (32'd1 << AW));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic step();
        bit dq, g_d, g_i;
        logic [AW-1:0] a;
        @(posedge clk); #1;
        rst = 1'b0;
        if_req = ip; if_addr = ia;
        d_read = dr; d_write = dw; d_addr = da; d_wdata = dwd; d_mask = dm;
        @(negedge clk);
        dq  = dr || dw;
        g_d = dq && !(ip && streak >= MAXS);
        g_i = ip && !g_d;
        if (ram_en && dq && !d_stall) dut_log = {dut_log, "D"};
        else if (ram_en) dut_log = {dut_log, "I"};
        else dut_log = {dut_log, "-"};
        chk("ram_en", ram_en, g_d || g_i);
        chk("if_stall", if_stall, ip && !g_i);
        chk("d_stall", d_stall, dq && !g_d);
        chk("err", err, err_exp);
        if (g_d) begin
            a = word_of(da);
            chk("ram_addr_d", ram_addr, a);
            chk("ram_we_d", ram_we, dw ? dm : 4'b0000);
            if (dw) begin
                chk("ram_wdata", ram_wdata, dwd);
                ref_mem[a] = merge(ref_mem[a], dwd, dm);
            end else begin
                d_q.push_back('{ref_mem[a], cyc + 1});
            end
        end else if (g_i) begin
            a = word_of(ia);
            chk("ram_addr_if", ram_addr, a);
            chk("ram_we_if", ram_we, 4'b0000);
            if_q.push_back('{ref_mem[a], cyc + 1});
        end
        if ((dr && dw) || (ip && ia[1:0] != 2'b00)) err_exp = 1;
        if (!ip || g_i) streak = 0;
        else if (g_d) streak++;
        if (g_d) begin dr = 0; dw = 0; end
        if (g_i) ip = 0;
    endtask

    // Requests are held high during reset to show grants and stalls are gated
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b1;
            if_req = 1'b1; if_addr = 32'h10; d_read = 1'b1; d_write = 1'b0;
            d_addr = 32'h20; d_mask = 4'hF;
            ip = 0; dr = 0; dw = 0;
            if_q.delete(); d_q.delete();
            streak = 0; err_exp = 0;
            @(negedge clk);
            chk("rst_ram_en", ram_en, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_if_valid", if_valid, 0);
            chk("rst_d_valid", d_valid, 0);
            chk("rst_if_stall", if_stall, 0);
            chk("rst_d_stall", d_stall, 0);
            chk("rst_err", err, 0);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_log(input string name, input string exp);
        checks++;
        if (dut_log != exp) begin
            errors++;
            $display("FAIL %s: got %s expected %s", name, dut_log, exp);
        end
    endtask

    // Monitor: any returned word must match the head of its queue, on time
    exp_t e_if, e_d;
    always @(negedge clk) begin
        #1;
        if (if_valid) begin
            if (if_q.size() == 0) chk("if_valid_unexpected", 1, 0);
            else begin
                e_if = if_q.pop_front();
                chk("if_rdata", if_rdata, e_if.data);
                chk("if_valid_cycle", cyc, e_if.due);
            end
        end else if (if_q.size() != 0 && if_q[0].due <= cyc) begin
            void'(if_q.pop_front());
            chk("if_valid_missing", 0, 1);
        end
        if (d_valid) begin
            if (d_q.size() == 0) chk("d_valid_unexpected", 1, 0);
            else begin
                e_d = d_q.pop_front();
                chk("d_rdata", d_rdata, e_d.data);
                chk("d_valid_cycle", cyc, e_d.due);
            end
        end else if (d_q.size() != 0 && d_q[0].due <= cyc) begin
            void'(d_q.pop_front());
            chk("d_valid_missing", 0, 1);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        mem[2] = 32'h11223344; ref_mem[2] = 32'h11223344;
        do_reset(3);

        // Lone fetch, then a fetch whose high address bits wrap onto word 4
        ip = 1; ia = 32'h10; step();
        ip = 1; ia = 32'hFFFF_F410; step();
        idle(2);

        // Simultaneous fetch and load: data first, fetch next cycle
        dut_log = "";
        ip = 1; ia = 32'h0; dr = 1; da = 32'h20; step(); step();
        chk_log("grant_order", "DI");
        idle(2);

        // Continuous loads with the fetch held
        do_reset(1);
        dut_log = "";
        for (int i = 0; i < 6; i++) begin
            if (!ip) begin ip = 1; ia = 32'h40; end
            if (!dr) begin dr = 1; da = 32'h44; end
            step();
        end
        chk_log("streak_pattern", "DDIDDI");
        idle(2);

        // Partial store then load of the same word
        dw = 1; da = 32'h8; dwd = 32'hAABBCCDD; dm = 4'b0011; step();
        dr = 1; da = 32'h8; step();
        idle(2);

        // Randomised traffic with held requests
        for (int i = 0; i < 500; i++) begin
            if (!ip && $urandom_range(0, 99) < 55) begin
                ip = 1; ia = $urandom & 32'hFFFF_FFFC;
            end
            if (!dr && !dw && $urandom_range(0, 99) < 55) begin
                if ($urandom_range(0, 1) == 1) dr = 1; else dw = 1;
                da = $urandom; dwd = $urandom; dm = 4'($urandom_range(1, 15));
            end
            step();
        end
        idle(3);

        // Reset in the cycle after a fetch grant drops the pending return
        ip = 1; ia = 32'h30; step();
        do_reset(2);
        idle(3);

        // Protocol errors are sticky until reset
        dr = 1; dw = 1; da = 32'h40; dwd = 32'h01020304; dm = 4'hF; step();
        idle(3);
        do_reset(1);
        ip = 1; ia = 32'h6; step();
        idle(3);
        do_reset(2);
        idle(2);

        chk("queues_drained", if_q.size() + d_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
